// File: rtl/fp_mul_r8.sv
// Radix-8 sequential unsigned significand multiplier: p = a * b, full 2*WID-bit product.
// Latency: ITER=(WID+2)/3 cycles from the ld edge to done; 0 extra cycles when an operand is zero.
// No backpressure: ld is always accepted and aborts any operation in flight.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset (wins over ld)
//   ld   - start pulse, samples a/b
//   a, b - WID-bit multiplicand / multiplier
//   p    - 2*WID-bit product, valid from done until next ld or rst
//   done - one-cycle pulse when p is valid
//   busy - high while iterations are in progress
module fp_mul_r8 #(
  parameter int WID = 112
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WID-1:0]   a,
  input  logic [WID-1:0]   b,
  output logic [2*WID-1:0] p,
  output logic             done,
  output logic             busy
);

  localparam int ITER = (WID + 2) / 3;
  localparam int MW   = 3 * ITER;          // zero-padded multiplier width
  localparam int AW   = WID + 3;           // accumulator width
  localparam int HW   = 2 * WID - MW;      // product bits taken from the accumulator
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [WID-1:0]   r_areg;
  logic [MW-1:0]    r_mreg;
  logic [AW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic [2*WID-1:0] r_p;
  logic             r_done;
  logic             r_busy;

  logic [2:0]       w_d;
  logic [AW-1:0]    w_a1;
  logic [AW-1:0]    w_pp;
  logic [AW-1:0]    w_s;
  logic [MW-1:0]    w_mreg_nx;
  logic [2*WID-1:0] w_p_nx;
  logic             w_zero;

  // Digit times multiplicand from shifted copies; 7*a fits in WID+3 bits.
  assign w_d  = r_mreg[2:0];
  assign w_a1 = {3'b000, r_areg};
  assign w_pp = (w_d[0] ? w_a1        : '0)
              + (w_d[1] ? (w_a1 << 1) : '0)
              + (w_d[2] ? (w_a1 << 2) : '0);
  assign w_s  = r_acc + w_pp;

  // Low 3 bits of each partial sum retire into the top of mreg as the
  // consumed digit drops out the bottom; after ITER steps mreg holds the
  // low MW product bits and the shifted accumulator holds the rest.
  assign w_mreg_nx = {w_s[2:0], r_mreg[MW-1:3]};
  assign w_p_nx    = {w_s[HW+2:3], w_mreg_nx};

  assign w_zero = (a == '0) || (b == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_areg  <= '0;
      r_mreg  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (ld) begin
        if (w_zero) begin
          // Trivial product: answer immediately, abandoning any run in flight.
          r_p     <= '0;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end else begin
          r_areg  <= a;
          r_mreg  <= MW'(b);
          r_acc   <= '0;
          r_cnt   <= CW'(ITER - 1);
          r_busy  <= 1'b1;
          r_state <= S_RUN;
        end
      end else if (r_state == S_RUN) begin
        r_acc  <= w_s >> 3;
        r_mreg <= w_mreg_nx;
        if (r_cnt == '0) begin
          r_p     <= w_p_nx;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

  assign p    = r_p;
  assign done = r_done;
  assign busy = r_busy;

endmodule

// File: tb/tb_fp_mul_r8.sv
// Directed bench for fp_mul_r8 at WID=8 (table plus corner sequences) and WID=112.
// Latency: inputs driven on falling edges, outputs sampled on falling edges.
// Backpressure: none; every wait on done is bounded by a cycle budget.
module tb_fp_mul_r8;

  logic         clk = 1'b0;
  logic         rst;
  logic         ld8, ld112;
  logic [7:0]   a8, b8;
  logic [15:0]  p8;
  logic         done8, busy8;
  logic [111:0] a112, b112;
  logic [223:0] p112;
  logic         done112, busy112;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_mul_r8 #(.WID(8)) dut8 (
    .clk(clk), .rst(rst), .ld(ld8), .a(a8), .b(b8),
    .p(p8), .done(done8), .busy(busy8)
  );

  fp_mul_r8 #(.WID(112)) dut112 (
    .clk(clk), .rst(rst), .ld(ld112), .a(a112), .b(b112),
    .p(p112), .done(done112), .busy(busy112)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec8_t;

  vec8_t vecs[11];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge just after the ld edge.
  task automatic start8(input logic [7:0] ia, input logic [7:0] ib);
    a8  = ia;
    b8  = ib;
    ld8 = 1'b1;
    @(negedge clk);
    ld8 = 1'b0;
  endtask

  task automatic start112(input logic [111:0] ia, input logic [111:0] ib);
    a112  = ia;
    b112  = ib;
    ld112 = 1'b1;
    @(negedge clk);
    ld112 = 1'b0;
  endtask

  // cyc = rising edges after the ld edge until done is seen (0 = raised by the ld edge).
  task automatic wait_done8(output int cyc, output int nbusy);
    cyc   = 0;
    nbusy = 0;
    while (!done8 && cyc < 60) begin
      if (busy8) nbusy++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_done112(output int cyc);
    cyc = 0;
    while (!done112 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic count_done8(input int n, output int ndone, output int nbusy);
    ndone = 0;
    nbusy = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done8) ndone++;
      if (busy8) nbusy++;
    end
  endtask

  task automatic run112(input logic [111:0] ia, input logic [111:0] ib);
    int cyc;
    logic [223:0] exp;
    exp = {112'b0, ia} * {112'b0, ib};
    start112(ia, ib);
    wait_done112(cyc);
    chk("lat112", cyc, (ia == '0 || ib == '0) ? 0 : 38);
    chk("p112", p112, exp);
  endtask

  function automatic logic [111:0] rnd112();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[111:0];
  endfunction

  initial begin
    int cyc, nb, nd;
    logic [111:0] ones, bit1;

    vecs[0]  = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[1]  = '{8'h00, 8'h5A, 16'h0000};
    vecs[2]  = '{8'h5A, 8'h00, 16'h0000};
    vecs[3]  = '{8'h07, 8'h06, 16'h002A};
    vecs[4]  = '{8'h80, 8'h02, 16'h0100};
    vecs[5]  = '{8'h03, 8'h05, 16'h000F};
    vecs[6]  = '{8'h01, 8'h01, 16'h0001};
    vecs[7]  = '{8'hFF, 8'h01, 16'h00FF};
    vecs[8]  = '{8'h12, 8'h34, 16'h03A8};
    vecs[9]  = '{8'h80, 8'h80, 16'h4000};
    vecs[10] = '{8'hAB, 8'hCD, 16'h88EF};

    rst   = 1'b1;
    ld8   = 1'b0;
    ld112 = 1'b0;
    a8    = '0;
    b8    = '0;
    a112  = '0;
    b112  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_p8", p8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_p112", p112, 0);
    chk("rst_done112", done112, 0);
    chk("rst_busy112", busy112, 0);

    // Table: latency, busy duration, product, single-cycle done.
    for (int i = 0; i < 11; i++) begin
      logic zero;
      zero = (vecs[i].a == 8'h00) || (vecs[i].b == 8'h00);
      start8(vecs[i].a, vecs[i].b);
      wait_done8(cyc, nb);
      chk($sformatf("lat8[%0d]", i), cyc, zero ? 0 : 3);
      chk($sformatf("busy8[%0d]", i), nb, zero ? 0 : 3);
      chk($sformatf("p8[%0d]", i), p8, vecs[i].p);
      @(negedge clk);
      chk($sformatf("pulse8[%0d]", i), done8, 0);
    end

    // Back-to-back: new ld in the done cycle; p holds until the new result.
    start8(8'h07, 8'h06);
    wait_done8(cyc, nb);
    chk("b2b_lat1", cyc, 3);
    chk("b2b_p1", p8, 16'h002A);
    start8(8'h80, 8'h02);
    chk("b2b_hold", p8, 16'h002A);
    chk("b2b_busy", busy8, 1);
    wait_done8(cyc, nb);
    chk("b2b_lat2", cyc, 3);
    chk("b2b_p2", p8, 16'h0100);

    // Abort mid-run with a new ld: only the second operation completes.
    @(negedge clk);
    start8(8'hAB, 8'hCD);
    @(negedge clk);
    start8(8'h03, 8'h05);
    wait_done8(cyc, nb);
    chk("abort_lat", cyc, 3);
    chk("abort_p", p8, 16'h000F);
    count_done8(6, nd, nb);
    chk("abort_extra_done", nd, 0);

    // ld held for three edges: done follows the last one.
    a8  = 8'h11;
    b8  = 8'h11;
    ld8 = 1'b1;
    repeat (2) @(negedge clk);
    start8(8'h11, 8'h11);
    wait_done8(cyc, nb);
    chk("hold_lat", cyc, 3);
    chk("hold_p", p8, 16'h0121);

    // Reset during RUN: no done, outputs cleared.
    @(negedge clk);
    start8(8'hAB, 8'hCD);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", busy8, 0);
    chk("mrst_done", done8, 0);
    chk("mrst_p", p8, 0);
    count_done8(6, nd, nb);
    chk("mrst_no_done", nd, 0);

    // Reset and ld together: reset wins.
    a8  = 8'h03;
    b8  = 8'h05;
    ld8 = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ld8 = 1'b0;
    chk("rstld_busy", busy8, 0);
    count_done8(5, nd, nb);
    chk("rstld_no_done", nd, 0);
    chk("rstld_no_busy", nb, 0);

    // WID=112: extremes, single-bit operands, random pairs.
    ones = '1;
    run112(ones, ones);
    run112(ones, 112'd1);
    run112('0, ones);
    for (int i = 0; i < 112; i++) begin
      bit1 = 112'd1 << i;
      if (i % 2 == 0) run112(bit1, rnd112());
      else            run112(ones, bit1);
    end
    for (int i = 0; i < 1000; i++) begin
      run112(rnd112(), rnd112());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
